fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter B, default 8, giving the data word width in bits; it matches the shared FIFO word width.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum number of beats in one packet before a forced release.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports req0, req1  input  1 each  requester N has a beat to write.
REQ-006 The block SHALL have ports data0, data1  input  B each  requester N beat data.
REQ-007 The block SHALL have ports last0, last1  input  1 each  the current beat of requester N is the final beat of its packet.
REQ-008 The block SHALL have ports ack0, ack1  output  1 each  the beat of requester N is written this cycle.
REQ-009 The block SHALL have port fifo_full  input  1  full flag of the shared FIFO.
REQ-010 The block SHALL have ports fifo_wr  output  1 and fifo_wdata  output  B  write strobe and data to the shared FIFO.
REQ-011 The block SHALL have port grant  output  2  one-hot current owner; 00 means idle.
REQ-012 The block SHALL have port err_len  output  1  one-cycle pulse on a forced release.

Function
REQ-013 The FSM SHALL have three states: IDLE, GNT0 and GNT1; grant SHALL be 01 in GNT0, 10 in GNT1 and 00 in IDLE.
REQ-014 In IDLE with exactly one reqN high, the next state SHALL be GNTN.
REQ-015 In IDLE with req0 and req1 both high, the next state SHALL be GNT of the side selected by the round-robin pointer prio.
REQ-016 In IDLE with neither request high, the FSM SHALL stay in IDLE.
REQ-017 No ack SHALL be issued in IDLE, so arbitration latency is one cycle from request to the first possible ack.
REQ-018 ackN SHALL be combinational and equal to (state==GNTN) & reqN & ~fifo_full.
REQ-019 fifo_wr SHALL equal ack0|ack1, and fifo_wdata SHALL equal dataN of the granted side (data0 when idle).
REQ-020 At most one ack SHALL be high in any cycle.
REQ-021 The grant SHALL be packet-atomic: in GNTN, a low reqN or a high fifo_full stalls the packet, and the grant is held with no timeout.
REQ-022 A beat counter cnt of width clog2(MAX_LEN+1) SHALL clear on entry to GNTx and increment on each ack.
REQ-023 An acked beat with lastN=1 SHALL move the FSM to IDLE on the next edge and set prio to the other side.
REQ-024 An acked beat without last that makes cnt reach MAX_LEN SHALL move the FSM to IDLE and pulse err_len for exactly one cycle.
REQ-025 In the forced-release case of REQ-024, prio SHALL also be set to the other side.
REQ-026 The release of REQ-023 and REQ-024 SHALL take effect even if reqN stays high.
REQ-027 When last=1 coincides with cnt reaching MAX_LEN, the transfer SHALL be treated as a normal release with no err_len.
REQ-028 A FIFO-full assertion in the same cycle as a last beat SHALL suppress both the ack and the release.
REQ-029 prio SHALL change only on a release.

Reset
REQ-030 While RESET is high, the block SHALL be in state IDLE with prio=0 (requester 0 favoured), cnt=0, err_len=0 and grant=00.
REQ-031 While RESET is high, ack0, ack1 and fifo_wr SHALL be 0.
REQ-032 A RESET mid-packet SHALL abandon the packet without any err_len pulse.

Structure
REQ-033 The state encodings and the ARB_IDLE/ARB_GNT0/ARB_GNT1 constants SHALL live in the shared BIP package (include file).
REQ-034 The block SHALL have no sub-module; the FIFO SHALL be instantiated beside it by the parent.

Verification
REQ-035 The bench SHALL drive reset release then req0 with 3 beats (last on the 3rd), and SHALL check that grant=01 one cycle later, ack0 is high for 3 cycles, fifo_wdata follows data0, and the FSM returns to IDLE.
REQ-036 The bench SHALL hold req0 and req1 high, each sending 2-beat packets, and SHALL check the order GNT0, GNT1, GNT0 with no interleaving within a packet.
REQ-037 The bench SHALL assert fifo_full for 4 cycles mid-packet and SHALL check that ack and fifo_wr are 0 for those cycles, the grant is held, and the packet resumes with no lost beat.
REQ-038 With MAX_LEN=4, the bench SHALL send 6 beats without last and SHALL check that the 4th ack causes a release, err_len pulses once, the grant passes to req1 if it is pending, and there is no err_len when last is on the 4th beat.
REQ-039 The bench SHALL assert RESET asynchronously in GNT1 after 2 beats and SHALL check that grant=00 and fifo_wr=0 immediately, prio=0 after release, and err_len=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter: state encodings
// (which double as the one-hot grant value) and the idle-state pick function.
package fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

    // Owner chosen from IDLE; prio breaks the tie when both sides request.
    function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                            input logic prio);
        arb_state_e pick;
        if (req0 && req1) begin
            pick = prio ? ARB_GNT1 : ARB_GNT0;
        end else if (req0) begin
            pick = ARB_GNT0;
        end else if (req1) begin
            pick = ARB_GNT1;
        end else begin
            pick = ARB_IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter merging two write streams into one shared
// FIFO, with a beat-count limit that forces release of a runaway packet.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int B       = 8,
    parameter int MAX_LEN = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         req0,
    input  logic         req1,
    input  logic [B-1:0] data0,
    input  logic [B-1:0] data1,
    input  logic         last0,
    input  logic         last1,
    output logic         ack0,
    output logic         ack1,
    input  logic         fifo_full,
    output logic         fifo_wr,
    output logic [B-1:0] fifo_wdata,
    output logic [1:0]   grant,
    output logic         err_len
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    logic             prio_r;
    logic             prio_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             err_len_r;
    logic             err_next_s;
    logic             ack0_s;
    logic             ack1_s;
    logic             own_ack_s;
    logic             own_last_s;

    // Beat handshake: acks depend on the current owner, its request and FIFO room.
    always_comb begin
        ack0_s     = (state_r == ARB_GNT0) && req0 && !fifo_full;
        ack1_s     = (state_r == ARB_GNT1) && req1 && !fifo_full;
        own_ack_s  = ack0_s || ack1_s;
        own_last_s = (state_r == ARB_GNT1) ? last1 : last0;
        fifo_wdata = (state_r == ARB_GNT1) ? data1 : data0;
    end

    assign ack0    = ack0_s;
    assign ack1    = ack1_s;
    assign fifo_wr = own_ack_s;
    assign grant   = state_r;
    assign err_len = err_len_r;

    // Next-state, beat counter and round-robin pointer; a last beat takes
    // precedence over the length limit so a packet of exactly MAX_LEN is clean.
    always_comb begin
        state_next_s = state_r;
        prio_next_s  = prio_r;
        cnt_next_s   = cnt_r;
        err_next_s   = 1'b0;
        cnt_inc_s    = cnt_r + CNT_W'(1'b1);
        case (state_r)
            ARB_IDLE: begin
                state_next_s = arb_pick(req0, req1, prio_r);
                cnt_next_s   = {CNT_W{1'b0}};
            end
            ARB_GNT0, ARB_GNT1: begin
                if (own_ack_s) begin
                    if (own_last_s || (cnt_inc_s == MAX_CNT)) begin
                        state_next_s = ARB_IDLE;
                        prio_next_s  = (state_r == ARB_GNT0) ? 1'b1 : 1'b0;
                        cnt_next_s   = {CNT_W{1'b0}};
                        err_next_s   = !own_last_s;
                    end else begin
                        cnt_next_s   = cnt_inc_s;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any packet silently.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ARB_IDLE;
            prio_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            err_len_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            prio_r    <= prio_next_s;
            cnt_r     <= cnt_next_s;
            err_len_r <= err_next_s;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (MAX_LEN=4 so the length
// limit is reachable with short packets).
module tb_fifo_wr_arbiter;

    logic       CLK;
    logic       RESET;
    logic       req0, req1, last0, last1, fifo_full;
    logic [7:0] data0, data1;
    logic       ack0, ack1, fifo_wr, err_len;
    logic [7:0] fifo_wdata;
    logic [1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] rr_grant [8] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1};
    logic [7:0] rr_ack0  = 8'b1000_0110;
    logic [7:0] rr_ack1  = 8'b0011_0000;

    fifo_wr_arbiter #(.B(8), .MAX_LEN(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .req0(req0), .req1(req1),
        .data0(data0), .data1(data1),
        .last0(last0), .last1(last1),
        .ack0(ack0), .ack1(ack1),
        .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .grant(grant), .err_len(err_len)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r0, input logic [7:0] d0, input logic l0,
                       input logic r1, input logic [7:0] d1, input logic l1,
                       input logic full);
        req0 = r0; data0 = d0; last0 = l0;
        req1 = r1; data1 = d1; last1 = l1;
        fifo_full = full;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        drv(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_wr", fifo_wr, 1'b0);
        check("rst_err", err_len, 1'b0);
        tick();
        RESET = 1'b0;

        // Single 3-beat packet on requester 0
        drv(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("p3_idle_grant", grant, 2'b00);
        check("p3_idle_ack", ack0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'hA1 + 8'(i), (i == 2), 1'b0, 8'h00, 1'b0, 1'b0);
            check("p3_grant", grant, 2'b01);
            check("p3_ack0", ack0, 1'b1);
            check("p3_wr", fifo_wr, 1'b1);
            check("p3_wdata", fifo_wdata, 8'hA1 + 8'(i));
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("p3_back_idle", grant, 2'b00);
        check("p3_no_err", err_len, 1'b0);

        // Both requesters with 2-beat packets: GNT0, GNT1, GNT0
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drv(1'b1, 8'h10 + 8'(c), (c == 2), 1'b1, 8'h20 + 8'(c), (c == 5), 1'b0);
            check("rr_grant", grant, rr_grant[c]);
            check("rr_ack0", ack0, rr_ack0[c]);
            check("rr_ack1", ack1, rr_ack1[c]);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b1, 8'h28, 1'b1, 1'b0);
        check("rr_hold_grant", grant, 2'b01);
        check("rr_hold_ack1", ack1, 1'b0);
        check("rr_hold_wr", fifo_wr, 1'b0);
        tick();
        check("rr_hold_grant2", grant, 2'b01);

        // FIFO full for 4 cycles mid-packet, then full on the last beat
        do_reset();
        drv(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        drv(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ff_b1_ack", ack0, 1'b1);
        check("ff_b1_data", fifo_wdata, 8'hC1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            check("ff_stall_ack", ack0, 1'b0);
            check("ff_stall_wr", fifo_wr, 1'b0);
            check("ff_stall_grant", grant, 2'b01);
            tick();
        end
        drv(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ff_b2_ack", ack0, 1'b1);
        check("ff_b2_data", fifo_wdata, 8'hC2);
        tick();
        drv(1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ff_last_full_ack", ack0, 1'b0);
        tick();
        drv(1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ff_last_held", grant, 2'b01);
        check("ff_b3_ack", ack0, 1'b1);
        check("ff_b3_data", fifo_wdata, 8'hC3);
        tick();
        drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ff_idle", grant, 2'b00);

        // Length limit: 4 beats without last force a release to pending req1
        do_reset();
        drv(1'b1, 8'hD0, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0);
            check("ml_grant", grant, 2'b01);
            check("ml_ack0", ack0, 1'b1);
            check("ml_ack1", ack1, 1'b0);
            check("ml_err_low", err_len, 1'b0);
            tick();
        end
        drv(1'b1, 8'hD4, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0);
        check("ml_release", grant, 2'b00);
        check("ml_err_pulse", err_len, 1'b1);
        check("ml_rel_ack0", ack0, 1'b0);
        tick();
        drv(1'b1, 8'hD4, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0);
        check("ml_to_req1", grant, 2'b10);
        check("ml_err_once", err_len, 1'b0);
        check("ml_ack1", ack1, 1'b1);
        check("ml_data1", fifo_wdata, 8'hE0);
        tick();
        drv(1'b1, 8'hD4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ml_idle2", grant, 2'b00);
        check("ml_idle2_err", err_len, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 8'hD4 + 8'(i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            check("ml_tail_ack", ack0, 1'b1);
            check("ml_tail_data", fifo_wdata, 8'hD4 + 8'(i));
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ml_tail_held", grant, 2'b01);
        check("ml_tail_err", err_len, 1'b0);

        // Last on the 4th beat: normal release, no error
        do_reset();
        drv(1'b1, 8'h50, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 8'h50 + 8'(i), (i == 3), 1'b0, 8'h00, 1'b0, 1'b0);
            check("ml4_ack", ack0, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("ml4_idle", grant, 2'b00);
        check("ml4_no_err", err_len, 1'b0);
        tick();
        check("ml4_no_err2", err_len, 1'b0);

        // Asynchronous reset in GNT1 after 2 beats
        do_reset();
        drv(1'b0, 8'h00, 1'b0, 1'b1, 8'h60, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 8'h00, 1'b0, 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
            check("ar_grant", grant, 2'b10);
            check("ar_ack1", ack1, 1'b1);
            tick();
        end
        drv(1'b0, 8'h00, 1'b0, 1'b1, 8'h62, 1'b0, 1'b0);
        check("ar_pre_wr", fifo_wr, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check("ar_grant0", grant, 2'b00);
        check("ar_wr0", fifo_wr, 1'b0);
        check("ar_ack1_0", ack1, 1'b0);
        check("ar_err0", err_len, 1'b0);
        tick();
        RESET = 1'b0;
        drv(1'b1, 8'h70, 1'b0, 1'b1, 8'h63, 1'b0, 1'b0);
        check("ar_post_idle", grant, 2'b00);
        check("ar_post_err", err_len, 1'b0);
        tick();
        check("ar_prio0", grant, 2'b01);
        check("ar_post_err2", err_len, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
